restador_acumulado: RTL and testbench



---
 rtl/restador_acumulado.sv | 105 ++++++++++
 tb/tb_restador_acumulado.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/restador_acumulado.sv
// Down-accumulator: loads a value, subtracts a selected operand per valid cycle.
// Define RESTADOR_SATURATE_EN to clamp to 0 on borrow instead of wrapping.
module restador_acumulado #(
   parameter int NB_DATA = 3,
   parameter int NB_CNT  = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_load,
   input  logic [2*NB_DATA-1:0]   i_load_data,
   input  logic                   i_valid,
   input  logic [NB_DATA-1:0]     i_data1,
   input  logic [NB_DATA-1:0]     i_data2,
   input  logic [1:0]             i_sel,
   output logic [2*NB_DATA-1:0]   o_data,
   output logic                   o_underflow,
   output logic                   o_zero,
   output logic                   o_busy,
   output logic [NB_CNT-1:0]      o_ops
);

   localparam int NB_V = 2*NB_DATA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      HALT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [NB_V-1:0]   value_q, value_d;
   logic [NB_CNT-1:0] ops_q, ops_d;
   logic              uf_q, uf_d;

   logic [NB_DATA:0]  sub;
   logic [NB_V:0]     diff;
   logic              borrow;
   logic              take;

   always_comb begin
      sub = '0;
      unique case (i_sel)
         2'b00: sub = {1'b0, i_data2};
         2'b01: sub = {1'b0, i_data1} + {1'b0, i_data2};
         2'b10: sub = {1'b0, i_data1};
         2'b11: sub = '0;
         default: sub = '0;
      endcase
   end

   assign diff   = {1'b0, value_q} - {{(NB_V-NB_DATA){1'b0}}, sub};
   assign borrow = diff[NB_V];
   assign take   = (state_q == RUN) && i_valid && (i_sel != 2'b11);

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      ops_d   = ops_q;
      uf_d    = uf_q;
      if (i_load) begin
         state_d = RUN;
         value_d = i_load_data;
         ops_d   = '0;
         uf_d    = 1'b0;
      end else if (take) begin
         ops_d = (ops_q == {NB_CNT{1'b1}}) ? ops_q : ops_q + NB_CNT'(1);
         if (borrow) begin
            state_d = HALT;
            uf_d    = 1'b1;
`ifdef RESTADOR_SATURATE_EN
            value_d = '0;
`else
            value_d = diff[NB_V-1:0];
`endif
         end else begin
            value_d = diff[NB_V-1:0];
            if (diff[NB_V-1:0] == '0) begin
               state_d = DONE;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         value_q <= '0;
         ops_q   <= '0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         ops_q   <= ops_d;
         uf_q    <= uf_d;
      end
   end

   assign o_data      = value_q;
   assign o_underflow = uf_q;
   assign o_ops       = ops_q;
   assign o_zero      = (state_q == DONE);
   assign o_busy      = (state_q == RUN);

endmodule

// File: tb/tb_restador_acumulado.sv
// Bench for restador_acumulado: directed plan, saturation, async reset, random run.
// Reference model uses plain integer arithmetic on the behavioural rules.
module tb_restador_acumulado;

   localparam int NB_DATA = 3;
   localparam int NB_CNT  = 8;
   localparam int MOD     = 1 << (2*NB_DATA);
   localparam int OPS_MAX = (1 << NB_CNT) - 1;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam int M_HALT = 3;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic                 i_load;
   logic [2*NB_DATA-1:0] i_load_data;
   logic                 i_valid;
   logic [NB_DATA-1:0]   i_data1;
   logic [NB_DATA-1:0]   i_data2;
   logic [1:0]           i_sel;
   logic [2*NB_DATA-1:0] o_data;
   logic                 o_underflow;
   logic                 o_zero;
   logic                 o_busy;
   logic [NB_CNT-1:0]    o_ops;

   int checks = 0;
   int errors = 0;
   int m_val, m_ops, m_uf, m_st;

   restador_acumulado #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_load(i_load),
      .i_load_data(i_load_data),
      .i_valid(i_valid),
      .i_data1(i_data1),
      .i_data2(i_data2),
      .i_sel(i_sel),
      .o_data(o_data),
      .o_underflow(o_underflow),
      .o_zero(o_zero),
      .o_busy(o_busy),
      .o_ops(o_ops)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data"}, 32'(o_data), m_val);
      chk({tag, ".uf"}, 32'(o_underflow), m_uf);
      chk({tag, ".zero"}, 32'(o_zero), (m_st == M_DONE) ? 1 : 0);
      chk({tag, ".busy"}, 32'(o_busy), (m_st == M_RUN) ? 1 : 0);
      chk({tag, ".ops"}, 32'(o_ops), m_ops);
   endtask

   task automatic model_reset();
      m_val = 0; m_ops = 0; m_uf = 0; m_st = M_IDLE;
   endtask

   task automatic model_step();
      int s;
      case (i_sel)
         2'd0: s = int'(i_data2);
         2'd1: s = int'(i_data1) + int'(i_data2);
         2'd2: s = int'(i_data1);
         default: s = 0;
      endcase
      if (i_load) begin
         m_val = int'(i_load_data);
         m_ops = 0; m_uf = 0; m_st = M_RUN;
      end else if (m_st == M_RUN && i_valid && i_sel != 2'd3) begin
         if (m_ops < OPS_MAX) m_ops++;
         if (s > m_val) begin
            m_uf = 1;
            m_st = M_HALT;
`ifdef RESTADOR_SATURATE_EN
            m_val = 0;
`else
            m_val = (m_val - s + MOD) % MOD;
`endif
         end else begin
            m_val = m_val - s;
            if (m_val == 0) m_st = M_DONE;
         end
      end
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge i_clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic ld, input int ldd, input logic v,
                        input int sel, input int d1, input int d2);
      i_load      = ld;
      i_load_data = (2*NB_DATA)'(ldd);
      i_valid     = v;
      i_sel       = 2'(sel);
      i_data1     = NB_DATA'(d1);
      i_data2     = NB_DATA'(d2);
   endtask

   initial begin
      i_rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_all("reset");
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      check_all("idle");
      drive(0, 0, 1, 0, 3, 3);
      tick("idle_valid");

      drive(1, 20, 0, 0, 0, 0);
      tick("tp1_load");
      drive(0, 0, 1, 1, 3, 4);
      tick("tp1_sub");
      chk("tp1_const", 32'(o_data), 13);

      drive(1, 6, 0, 0, 0, 0);
      tick("tp2_load");
      drive(0, 0, 1, 0, 0, 3);
      tick("tp2_s1");
      tick("tp2_s2");
      chk("tp2_zero", 32'(o_zero), 1);
      tick("tp2_ign");
      chk("tp2_ops", 32'(o_ops), 2);

      drive(1, 5, 0, 0, 0, 0);
      tick("tp3_load");
      drive(0, 0, 1, 2, 7, 0);
      tick("tp3_borrow");
`ifdef RESTADOR_SATURATE_EN
      chk("tp3_const", 32'(o_data), 0);
`else
      chk("tp3_const", 32'(o_data), 62);
`endif
      tick("tp3_hold");

      drive(1, 40, 1, 2, 1, 0);
      tick("tp4_prio");
      chk("tp4_const", 32'(o_data), 40);

      drive(1, 30, 0, 0, 0, 0);
      tick("tp5_load");
      drive(0, 0, 1, 3, 5, 5);
      repeat (3) tick("tp5_hold");
      chk("tp5_const", 32'(o_data), 30);
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      drive(0, 0, 0, 0, 0, 0);
      #1;
      i_rst_n = 1'b1;

      drive(1, 0, 0, 0, 0, 0);
      tick("zero_load");
      drive(0, 0, 1, 3, 0, 0);
      tick("zero_sel3");
      drive(0, 0, 1, 0, 0, 1);
      tick("zero_borrow");

      drive(1, 63, 0, 0, 0, 0);
      tick("sat_load");
      drive(0, 0, 1, 0, 0, 0);
      repeat (260) tick("sat_run");
      chk("ops_sat", 32'(o_ops), OPS_MAX);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 7) == 0), int'($urandom_range(0, MOD-1)),
               1'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
